// File: rtl/unique0_if_unit_if.sv
// unique0_if_unit_if: request/result bundle between a requester and the condition evaluator
interface unique0_if_unit_if #(parameter int WIDTH = 32, parameter int CNT_W = 16);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             has_else;
  logic             out_valid;
  logic [1:0]       branch;
  logic [2:0]       hit_vec;
  logic             overlap_err;
  logic             nomatch_err;
  logic [CNT_W-1:0] ovl_cnt;
  logic [CNT_W-1:0] nom_cnt;
  modport master (
    output in_valid, a, b, mode, has_else,
    input  out_valid, branch, hit_vec, overlap_err, nomatch_err, ovl_cnt, nom_cnt
  );
  modport slave (
    input  in_valid, a, b, mode, has_else,
    output out_valid, branch, hit_vec, overlap_err, nomatch_err, ovl_cnt, nom_cnt
  );
endinterface

// File: rtl/unique0_if_unit.sv
// unique0_if_unit: registered unique0/unique/priority if-chain evaluator with saturating violation counters
module unique0_if_unit #(
  parameter int WIDTH  = 32,
  parameter int THRESH = 100,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  unique0_if_unit_if.slave bus
);
  localparam logic signed [WIDTH-1:0] THR = WIDTH'(THRESH);
  logic signed [WIDTH-1:0] sa, sb;
  logic [2:0] hit;
  logic [1:0] brn;
  logic ovl, nom;
  logic out_valid_q, out_valid_d;
  logic [1:0] branch_q, branch_d;
  logic [2:0] hit_vec_q, hit_vec_d;
  logic overlap_err_q, overlap_err_d;
  logic nomatch_err_q, nomatch_err_d;
  logic [CNT_W-1:0] ovl_cnt_q, ovl_cnt_d;
  logic [CNT_W-1:0] nom_cnt_q, nom_cnt_d;
  always_comb begin
    sa = $signed(bus.a);
    sb = $signed(bus.b);
    hit = {sa < THR, sa < sb, sa == sb};
    brn = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
    // popcount >= 2; unique modes are those with mode[1] clear
    ovl = bus.in_valid && !bus.mode[1] && ((hit[0] & hit[1]) | (hit[0] & hit[2]) | (hit[1] & hit[2]));
    nom = bus.in_valid && (bus.mode != 2'd0) && (hit == 3'b000) && !bus.has_else;
    out_valid_d = bus.in_valid;
    branch_d = bus.in_valid ? brn : branch_q;
    hit_vec_d = bus.in_valid ? hit : hit_vec_q;
    overlap_err_d = ovl;
    nomatch_err_d = nom;
    ovl_cnt_d = (ovl && !(&ovl_cnt_q)) ? ovl_cnt_q + CNT_W'(1) : ovl_cnt_q;
    nom_cnt_d = (nom && !(&nom_cnt_q)) ? nom_cnt_q + CNT_W'(1) : nom_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      branch_q      <= 2'd3;
      hit_vec_q     <= 3'b000;
      overlap_err_q <= 1'b0;
      nomatch_err_q <= 1'b0;
      ovl_cnt_q     <= '0;
      nom_cnt_q     <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      branch_q      <= branch_d;
      hit_vec_q     <= hit_vec_d;
      overlap_err_q <= overlap_err_d;
      nomatch_err_q <= nomatch_err_d;
      ovl_cnt_q     <= ovl_cnt_d;
      nom_cnt_q     <= nom_cnt_d;
    end
  end
  assign bus.out_valid   = out_valid_q;
  assign bus.branch      = branch_q;
  assign bus.hit_vec     = hit_vec_q;
  assign bus.overlap_err = overlap_err_q;
  assign bus.nomatch_err = nomatch_err_q;
  assign bus.ovl_cnt     = ovl_cnt_q;
  assign bus.nom_cnt     = nom_cnt_q;
endmodule

// File: tb/tb_unique0_if_unit.sv
// tb_unique0_if_unit: random + directed scoreboard bench for unique0_if_unit (CNT_W=4 to reach saturation)
module tb_unique0_if_unit;
  localparam int CW = 4;
  typedef struct packed {
    logic          v;
    logic [1:0]    br;
    logic [2:0]    hit;
    logic          ov;
    logic          nm;
    logic [CW-1:0] oc;
    logic [CW-1:0] nc;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  unique0_if_unit_if #(.WIDTH(32), .CNT_W(CW)) bus();
  unique0_if_unit #(.WIDTH(32), .THRESH(100), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int m_br = 3, m_hit = 0, m_oc = 0, m_nc = 0;
  bit done = 0;
  function automatic int sat_inc(input int c);
    return (c + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : c + 1;
  endfunction
  // Reference: evaluate the if-chain from its rules and push what the next cycle must show
  task automatic drive(input bit r, input bit v, input int a, input int b, input int mode, input bit he);
    exp_t e;
    int h[3];
    int n;
    @(negedge clk);
    rst = r; bus.in_valid = v; bus.a = a; bus.b = b; bus.mode = mode[1:0]; bus.has_else = he;
    e = '0;
    if (r) begin
      m_br = 3; m_hit = 0; m_oc = 0; m_nc = 0;
    end else if (v) begin
      h[0] = (a == b); h[1] = (a < b); h[2] = (a < 100);
      n = h[0] + h[1] + h[2];
      m_hit = h[0] + 2 * h[1] + 4 * h[2];
      m_br = 3;
      for (int i = 2; i >= 0; i--) if (h[i] != 0) m_br = i;
      e.v = 1;
      e.ov = (mode <= 1) && (n >= 2);
      e.nm = (mode >= 1) && (n == 0) && !he;
      if (e.ov) m_oc = sat_inc(m_oc);
      if (e.nm) m_nc = sat_inc(m_nc);
    end
    e.br = m_br[1:0]; e.hit = m_hit[2:0]; e.oc = m_oc[CW-1:0]; e.nc = m_nc[CW-1:0];
    q.push_back(e);
  endtask
  initial begin
    exp_t g, e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        g = {bus.out_valid, bus.branch, bus.hit_vec, bus.overlap_err, bus.nomatch_err, bus.ovl_cnt, bus.nom_cnt};
        e = q.pop_front();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL cycle t=%0t: got v=%b br=%0d hit=%b ov=%b nm=%b oc=%0d nc=%0d, want v=%b br=%0d hit=%b ov=%b nm=%b oc=%0d nc=%0d",
                   $time, g.v, g.br, g.hit, g.ov, g.nm, g.oc, g.nc, e.v, e.br, e.hit, e.ov, e.nm, e.oc, e.nc);
        end
      end
    end
  end
  function automatic int pick();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 16)) - 8;
      1: return int'($urandom_range(90, 110));
      2: return -int'($urandom_range(0, 300));
      default: return int'($urandom);
    endcase
  endfunction
  initial begin
    int a, b;
    rst = 1; bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.mode = 0; bus.has_else = 1;
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 1, 50, 100, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 50, 100, 0, 1);
    drive(0, 1, 50, 100, 2, 1);
    drive(0, 1, 150, 150, 1, 1);
    drive(0, 1, 7, 7, 0, 1);
    drive(0, 1, 200, 100, 0, 0);
    drive(0, 1, 200, 100, 1, 0);
    drive(0, 1, 200, 100, 2, 1);
    drive(0, 1, 200, 100, 3, 0);
    drive(0, 0, 1, 2, 1, 0);
    drive(0, 1, -5, 3, 2, 1);
    drive(0, 1, -100, -200, 2, 1);
    drive(0, 1, 100, 100, 0, 0);
    drive(0, 1, 99, 99, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      a = pick();
      b = ($urandom_range(0, 4) == 0) ? a : pick();
      drive(0, $urandom_range(0, 3) != 0, a, b, $urandom_range(0, 3), $urandom_range(0, 1));
    end
    drive(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) drive(0, 1, 50, 100, 0, 1);
    for (int i = 0; i < 20; i++) drive(0, 1, 200, 100, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unique0_if_unit.md
# unique0_if_unit

Registered three-way condition evaluator with SystemVerilog `unique0` / `unique` / `priority` if-else semantics in hardware. It evaluates a fixed ordered chain `a==b`, `a<b`, `a<THRESH`, then else, on signed operands. It reports the branch that executes, the raw condition hits, and single-cycle violation pulses with saturating violation counters. It is a checker/decision leaf for datapath comparison logic and for teaching benches.

## Interface
- WIDTH, 32, operand width in bits; operands are two's-complement signed.
- THRESH, 100, signed constant compared against `a` in condition 2.
- CNT_W, 16, width of each violation counter.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  one evaluation request per asserted cycle.
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B.
- mode  in  2  0 = unique0, 1 = unique, 2 = priority, 3 = priority (alias).
- has_else  in  1  1 = chain has a final else; 0 = no else.
- out_valid  out  1  result-valid pulse.
- branch  out  2  executed branch: 0 `a==b`, 1 `a<b`, 2 `a<THRESH`, 3 else/none.
- hit_vec  out  3  bit0 `a==b`, bit1 `a<b`, bit2 `a<THRESH`.
- overlap_err  out  1  more than one condition true under a unique mode.
- nomatch_err  out  1  no condition true and no else, under unique or priority.
- ovl_cnt  out  CNT_W  count of overlap_err pulses, saturating.
- nom_cnt  out  CNT_W  count of nomatch_err pulses, saturating.

## Operation
- All comparisons are signed.
- hit_vec = {a<THRESH, a<b, a==b}. All three conditions are always evaluated in parallel.
- branch = index of the lowest set bit of hit_vec, in every mode.
  - branch = 3 when hit_vec == 0, regardless of has_else.
  - Under unique/unique0, hardware still resolves overlaps deterministically by lowest index.
- overlap_err = (mode is 0 or 1) and popcount(hit_vec) ≥ 2.
- nomatch_err = (mode is 1, 2 or 3) and hit_vec == 0 and has_else == 0.
  - Under unique0 (mode 0), nomatch_err is never asserted.
- Conditions 0 and 1 are mutually exclusive, so overlap can only be condition 2 combined with condition 0 or 1.
- Counters:
  - ovl_cnt increments by 1 on each cycle overlap_err is asserted.
  - nom_cnt increments by 1 on each cycle nomatch_err is asserted.
  - Both stop at all-ones (saturate, no wrap).

## Timing
- Latency is 1 cycle. Inputs sampled on edge N with in_valid = 1 produce out_valid = 1 with matching branch, hit_vec and error flags after edge N.
- Full throughput: back-to-back in_valid gives back-to-back results.
- When in_valid = 0:
  - out_valid, overlap_err and nomatch_err are 0 the following cycle.
  - branch and hit_vec hold their last values.
- Error flags are only ever high in cycles where out_valid = 1.
- A counter increments in the same edge that registers its error flag, so its new value is visible alongside the flag.
- Reset values: out_valid 0, branch 3, hit_vec 0, overlap_err 0, nomatch_err 0, ovl_cnt 0, nom_cnt 0.
- Reset has priority over in_valid in the same cycle. A request presented during reset is discarded and no result is produced.
- mode and has_else are sampled together with a/b; no other state depends on them.

## Test plan
- Reset, then check all outputs; assert rst together with in_valid → out_valid stays 0 and counters stay 0.
- a=50, b=100, mode 0, has_else 1 → next cycle hit_vec=3'b110, branch=1, overlap_err=1, ovl_cnt=1. Repeat with mode 2 → branch=1, overlap_err=0, ovl_cnt unchanged.
- a=150, b=150, mode 1 → hit_vec=3'b001, branch=0, no errors. a=7, b=7, mode 0 → hit_vec=3'b101, branch=0, overlap_err=1.
- a=200, b=100, has_else 0:
  - mode 0 → hit_vec=0, branch=3, nomatch_err=0.
  - mode 1 → nomatch_err=1, nom_cnt increments.
  - mode 2 with has_else 1 → nomatch_err=0.
- Signed check: a=-5, b=3, mode 2 → hit_vec=3'b110, branch=1. a=-100, b=-200 → hit_vec=3'b100, branch=2.
- Saturation: with CNT_W=4, 20 back-to-back overlapping requests → ovl_cnt reaches 15 and holds; out_valid high every cycle; out_valid drops 1 cycle after in_valid drops.
